// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the CPU sequencer and the instruction decoder.
//   - one-hot state index constants and the matching one-hot state values
//   - default opcode of the stp instruction
//   - opcode field positions inside the 16-bit instruction word
package cpu_pkg;

  localparam int ST_W      = 6;
  localparam int IDX_IDLE  = 0;
  localparam int IDX_FETCH = 1;
  localparam int IDX_EXEC1 = 2;
  localparam int IDX_EXEC2 = 3;
  localparam int IDX_EXEC3 = 4;
  localparam int IDX_HALT  = 5;

  localparam logic [ST_W-1:0] S_IDLE  = 6'b000001;
  localparam logic [ST_W-1:0] S_FETCH = 6'b000010;
  localparam logic [ST_W-1:0] S_EXEC1 = 6'b000100;
  localparam logic [ST_W-1:0] S_EXEC2 = 6'b001000;
  localparam logic [ST_W-1:0] S_EXEC3 = 6'b010000;
  localparam logic [ST_W-1:0] S_HALT  = 6'b100000;

  localparam logic [4:0] STP_CODE_DEF = 5'b11110;

  // Opcode fields: 3-bit major opcode [15:13], 5-bit full opcode [15:11].
  localparam int OPC3_HI = 15;
  localparam int OPC3_LO = 13;
  localparam int OPC5_HI = 15;
  localparam int OPC5_LO = 11;

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: phase sequencer + instruction register for the 16-bit
// accumulator CPU.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   run, step           free-run level / single-instruction pulse
//   rom_q[15:0]         program ROM data, captured in FETCH
//   extra, extra2       decoder requests for EXEC2 / EXEC3
//   instr[15:0]         instruction register
//   fetch..exec3        one-hot phase strobes (straight from state flops)
//   halted, busy        HALT state / any active phase
//   instr_count         retired-instruction counter, wraps
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [4:0] STP_CODE = STP_CODE_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  input  logic [15:0]      rom_q,
  input  logic             extra,
  input  logic             extra2,
  output logic [15:0]      instr,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic             exec3,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  logic [ST_W-1:0] state, state_nxt;
  logic            retire;
  // Set one edge after reset release; holds IDLE for that first edge so the
  // earliest FETCH follows the second rising edge after reset_n rises.
  logic            armed;

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_IDLE:  if (armed && (run || step)) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC1;
      S_EXEC1: begin
        if (instr[OPC5_HI:OPC5_LO] == STP_CODE) begin
          state_nxt = S_HALT;
          retire    = 1'b1;
        end else if (extra) begin
          state_nxt = S_EXEC2;
        end else begin
          retire    = 1'b1;
          state_nxt = run ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC2: begin
        if (extra2) begin
          state_nxt = S_EXEC3;
        end else begin
          retire    = 1'b1;
          state_nxt = run ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC3: begin
        retire    = 1'b1;
        state_nxt = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;  // illegal encoding recovers to IDLE
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      armed       <= 1'b0;
      instr       <= 16'h0000;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (state[IDX_FETCH]) instr <= rom_q;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign fetch  = state[IDX_FETCH];
  assign exec1  = state[IDX_EXEC1];
  assign exec2  = state[IDX_EXEC2];
  assign exec3  = state[IDX_EXEC3];
  assign halted = state[IDX_HALT];
  assign busy   = state[IDX_FETCH] | state[IDX_EXEC1] | state[IDX_EXEC2] | state[IDX_EXEC3];

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0, step = 1'b0, extra = 1'b0, extra2 = 1'b0;
  logic [15:0] rom_q = 16'h0000;

  logic [15:0] instr, instr4;
  logic        fetch, exec1, exec2, exec3, halted, busy;
  logic        fetch4, exec14, exec24, exec34, halted4, busy4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  cpu_sequencer #(.CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step), .rom_q(rom_q),
    .extra(extra), .extra2(extra2), .instr(instr), .fetch(fetch), .exec1(exec1),
    .exec2(exec2), .exec3(exec3), .halted(halted), .busy(busy), .instr_count(cnt)
  );

  cpu_sequencer #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step), .rom_q(rom_q),
    .extra(extra), .extra2(extra2), .instr(instr4), .fetch(fetch4), .exec1(exec14),
    .exec2(exec24), .exec3(exec34), .halted(halted4), .busy(busy4), .instr_count(cnt4)
  );

  // Behavioural model: phase number (0 idle, 1 fetch, 2..4 exec n, 5 halt),
  // latched word and an unbounded retire count.
  int          m_ph;
  logic [15:0] m_ir;
  int          m_cnt;
  bit          m_armed;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = 0; m_ir = 16'h0; m_cnt = 0; m_armed = 0;
    end else begin
      if (m_ph == 0) begin
        if (m_armed && (run || step)) m_ph = 1;
      end else if (m_ph == 1) begin
        m_ir = rom_q; m_ph = 2;
      end else if (m_ph == 5) begin
        m_ph = 5;
      end else begin
        // Instruction is over when the stp code is seen, or the decoder does
        // not ask for the next phase.
        if (m_ph == 2 && m_ir[15:11] == 5'b11110) begin
          m_cnt++; m_ph = 5;
        end else if ((m_ph == 2 && extra) || (m_ph == 3 && extra2)) begin
          m_ph++;
        end else begin
          m_cnt++; m_ph = run ? 1 : 0;
        end
      end
      m_armed = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_en && reset_n) begin
      chk("m_phase", {26'd0, halted, exec3, exec2, exec1, fetch, busy},
          {26'd0, m_ph == 5, m_ph == 4, m_ph == 3, m_ph == 2, m_ph == 1, (m_ph >= 1 && m_ph <= 4)});
      chk("m_instr", {16'd0, instr}, {16'd0, m_ir});
      chk("m_cnt16", {16'd0, cnt}, 32'(m_cnt[15:0]));
      chk("m_cnt4", {28'd0, cnt4}, 32'(m_cnt[3:0]));
      chk("m_dut4_phase", {26'd0, halted4, exec34, exec24, exec14, fetch4, busy4},
          {26'd0, halted, exec3, exec2, exec1, fetch, busy});
    end
  end

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) edge1();
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_state", {26'd0, fetch, exec1, exec2, exec3, halted, busy}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_cnt", {16'd0, cnt}, 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    // Test 1: ldi free-run
    run = 1; rom_q = 16'h8005; extra = 0; extra2 = 0;
    do_reset();
    cmp_en = 1;
    edge1();  chk("t1_arm_idle", {31'd0, fetch}, 32'd0);
    edge1();  chk("t1_fetch", {31'd0, fetch}, 32'd1);
    edge1();  chk("t1_exec1", {31'd0, exec1}, 32'd1);
              chk("t1_instr", {16'd0, instr}, 32'h8005);
    edge1();  chk("t1_fetch2", {31'd0, fetch}, 32'd1);
              chk("t1_cnt", {16'd0, cnt}, 32'd1);

    // Test 2: ldn, 4-cycle instruction
    rom_q = 16'h4003; extra = 1; extra2 = 1;
    do_reset();
    edges(2); chk("t2_fetch", {31'd0, fetch}, 32'd1);
    edges(3); chk("t2_exec3", {31'd0, exec3}, 32'd1);
              chk("t2_cnt_pre", {16'd0, cnt}, 32'd0);
    edge1();  chk("t2_fetch2", {31'd0, fetch}, 32'd1);
              chk("t2_cnt", {16'd0, cnt}, 32'd1);

    // Test 3: stp halts, absorbing under toggling run/step
    rom_q = 16'hF000; extra = 0; extra2 = 0;
    do_reset();
    edges(4); chk("t3_halt", {30'd0, halted, busy}, 32'b10);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); run = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
    end
    edge1();
    chk("t3_halt_end", {26'd0, halted, busy, fetch, exec1, exec2, exec3}, 32'b100000);
    chk("t3_cnt", {16'd0, cnt}, 32'd1);

    // Test 4: single step of sta, second step during EXEC1 ignored
    run = 0; step = 0; rom_q = 16'h2001;
    do_reset();
    edge1();
    @(negedge clk); step = 1;
    edge1();  chk("t4_fetch", {31'd0, fetch}, 32'd1);
    @(negedge clk); step = 0;
    edge1();  chk("t4_exec1", {31'd0, exec1}, 32'd1);
    @(negedge clk); step = 1;
    edge1();  chk("t4_idle", {30'd0, fetch, busy}, 32'd0);
              chk("t4_cnt", {16'd0, cnt}, 32'd1);
    @(negedge clk); step = 0;
    edges(2); chk("t4_stay", {30'd0, fetch, busy}, 32'd0);

    // Test 5: async reset mid-EXEC2 of ldn
    run = 1; rom_q = 16'h4003; extra = 1; extra2 = 1;
    do_reset();
    edges(8); chk("t5_exec2", {31'd0, exec2}, 32'd1);
              chk("t5_cnt_pre", {16'd0, cnt}, 32'd1);
    #2 reset_n = 0;
    #1;
    chk("t5_async", {8'd0, 7'd0, exec2, instr}, 32'd0);
    chk("t5_async_cnt", {16'd0, cnt}, 32'd0);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);

    // Test 6: counter wrap on 4-bit instance
    rom_q = 16'h8005; extra = 0; extra2 = 0;
    do_reset();
    edges(32); chk("t6_cnt4_f", {28'd0, cnt4}, 32'hF);
    edges(2);  chk("t6_cnt4_wrap", {28'd0, cnt4}, 32'h0);
               chk("t6_cnt16", {16'd0, cnt}, 32'd16);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
